// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between the CPU and a DMA/boot master, with a starvation guard for the DMA.
// Optional MEM_ARB_STATS_EN adds saturating grant/stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_dma_gnt,
  output logic [15:0]       stat_cpu_stall
`endif
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [1:0] CMD_READ   = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  owner_t     state_reg;
  owner_t     grant;
  owner_t     rd_owner;
  logic       rd_pending_reg;
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic       cpu_act;

  assign cpu_act = (cpu_mem_cmd == CMD_READ) || (cpu_mem_cmd == CMD_WRITE);

  // Nothing is granted while reset is held so no strobe leaks out mid-reset.
  always_comb begin
    grant = OWN_NONE;
    if (!reset) begin
      if (dma_req && (starve_cnt_reg == STARVE_MAX)) begin
        grant = OWN_DMA;
      end else if (cpu_act) begin
        grant = OWN_CPU;
      end else if (dma_req) begin
        grant = OWN_DMA;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    case (grant)
      OWN_CPU: begin
        ram_addr  = cpu_mem_addr;
        ram_wdata = cpu_wdata;
        ram_read  = (cpu_mem_cmd == CMD_READ);
        ram_write = (cpu_mem_cmd == CMD_WRITE);
      end
      OWN_DMA: begin
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        ram_read  = !dma_we;
        ram_write = dma_we;
      end
      default: begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
      end
    endcase
  end

  assign dma_gnt  = (grant == OWN_DMA);
  assign cpu_wait = !reset && cpu_act && (grant != OWN_CPU);

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!dma_req || (grant == OWN_DMA)) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= OWN_NONE;
      rd_pending_reg <= 1'b0;
      starve_cnt_reg <= 4'd0;
      cpu_rdata_reg  <= '0;
    end else begin
      state_reg      <= grant;
      rd_pending_reg <= ram_read;
      starve_cnt_reg <= starve_cnt_next;
      if (rd_owner == OWN_CPU) begin
        cpu_rdata_reg <= ram_rdata;
      end
    end
  end

  // The owner of last cycle's read is last cycle's winner, qualified by whether it read.
  assign rd_owner = rd_pending_reg ? state_reg : OWN_NONE;

  // RAM data passes straight through in the return cycle and is held afterwards for IF2.
  assign cpu_rdata  = (rd_owner == OWN_CPU) ? ram_rdata : cpu_rdata_reg;
  assign dma_rvalid = (rd_owner == OWN_DMA);
  assign dma_rdata  = dma_rvalid ? ram_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dma_gnt   <= 16'd0;
      stat_cpu_stall <= 16'd0;
    end else begin
      if (dma_gnt && (stat_dma_gnt != 16'hFFFF)) begin
        stat_dma_gnt <= stat_dma_gnt + 16'd1;
      end
      if (cpu_wait && (stat_cpu_stall != 16'hFFFF)) begin
        stat_cpu_stall <= stat_cpu_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction RAM between the CPU controller and a secondary bus master (DMA/boot loader).
- Sits between the CPU memory interface (mem_cmd, address, write data) and the RAM.
- The CPU has default priority. A starvation counter guarantees the DMA master forward progress; when it fires, the CPU is stalled for one cycle.
- Read data is steered back to whichever requester issued the read. RAM has 1-cycle read latency.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 16, RAM data width.
- STARVE_LIM, 4, consecutive denied DMA request cycles before the DMA is force-granted (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_mem_cmd  in  2  00 = MNONE, 01 = MREAD, 10 = MWRITE, 11 = treated as MNONE.
- cpu_mem_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data returned to the CPU.
- cpu_wait  out  1  CPU access not performed this cycle; the CPU holds its state and mem_cmd.
- dma_req  in  1  DMA requests an access; held until granted.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  dma_rdata valid (cycle after a granted DMA read).
- dma_rdata  out  DATA_W  read data returned to the DMA.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_read  out  1  RAM read strobe; data is on ram_rdata the next cycle.
- ram_write  out  1  RAM write strobe; written at the clock edge.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- cpu_act = (cpu_mem_cmd == 01 or 10).
- Grant is decided combinationally each cycle from inputs and the registered state.
- State register values:
  - OWN_NONE: RAM idle.
  - OWN_CPU: CPU owns the port.
  - OWN_DMA: DMA owns the port.
  - A 4-bit starve_cnt accompanies the state.
- Grant rules, in priority order:
  - (a) dma_req and starve_cnt == STARVE_LIM → DMA granted; cpu_wait = cpu_act.
  - (b) cpu_act → CPU granted; dma_gnt = 0.
  - (c) dma_req → DMA granted.
  - (d) otherwise → none granted.
- Winner drives ram_addr, ram_wdata, ram_read and ram_write.
  - When no one is granted: ram_read = ram_write = 0, and ram_addr/ram_wdata = 0.
- starve_cnt update:
  - Cleared when DMA is granted or dma_req = 0.
  - Incremented when dma_req is denied.
  - Never exceeds STARVE_LIM.
- Read return:
  - A 2-bit rd_owner register records who issued a granted read.
  - Next cycle, cpu_rdata = ram_rdata if rd_owner = CPU.
  - Next cycle, dma_rvalid = 1 and dma_rdata = ram_rdata if rd_owner = DMA.
  - Otherwise cpu_rdata holds its last value; dma_rvalid = 0.
  - cpu_rdata is registered-hold, so the 2-cycle IF1/IF2 fetch sees stable data in IF2.
- Writes complete in the grant cycle; no response pulse.
- Simultaneous forced DMA grant plus CPU read:
  - CPU is stalled exactly one cycle.
  - The following cycle, CPU wins (starve_cnt = 0).
- Reset, including mid-access:
  - state = OWN_NONE, starve_cnt = 0, rd_owner = none, cpu_rdata = 0.
  - All strobes and grants/valids = 0.
  - An in-flight read is discarded; dma_rvalid is never asserted after reset for a pre-reset read.
- cpu_wait is 0 whenever cpu_act = 0.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs stat_dma_gnt[15:0] and stat_cpu_stall[15:0].
  - stat_dma_gnt counts DMA grant cycles; stat_cpu_stall counts cycles with cpu_wait = 1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Not defined: ports and logic are absent; arbitration behaviour is identical.

Test Plan:
- Reset, then CPU MREAD addr 9'h005 with RAM[5] = 16'hABCD → ram_read = 1 with ram_addr = 5 that cycle; cpu_rdata = 16'hABCD next cycle; cpu_wait = 0.
- CPU MNONE, dma_req = 1, dma_we = 1, addr 9'h010, data 16'h1234 → dma_gnt = 1, ram_write = 1 same cycle; a subsequent CPU read of 9'h010 returns 16'h1234.
- CPU continuous MREAD and dma_req held, STARVE_LIM = 4 → DMA denied for 4 cycles; in the 5th, dma_gnt = 1 and cpu_wait = 1; in the 6th, CPU granted and cpu_wait = 0.
- DMA read of 9'h020 (RAM = 16'h00FF) while CPU idle → dma_rvalid = 1 and dma_rdata = 16'h00FF one cycle after grant; cpu_rdata unchanged.
- cpu_mem_cmd = 11 with dma_req = 0 → no RAM strobes, cpu_wait = 0.
- Assert reset in the cycle after a DMA read grant → dma_rvalid stays 0; all outputs 0; starve_cnt restarts from 0.
